// File: rtl/dlx_bus_pkg.sv
// rtl/dlx_bus_pkg.sv - shared types and helpers for the DLX result-bus arbiter
//
// Purpose : arbiter state encoding, requester count and index/one-hot helper.
// Contents: state_t {IDLE, OWN, TURN}, NREQ, idx_to_onehot().
package dlx_bus_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin picker
//
// Purpose : choose the first set request bit scanning upward from ptr (mod 4).
// Ports   : req   [3:0] in  request vector
//           ptr   [1:0] in  highest-priority position
//           idx   [1:0] out winning index (0 when valid=0)
//           valid       out at least one request is set
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       valid
);

  logic [1:0] cand;

  // Scan from the farthest offset down to offset 0 so the position closest
  // to ptr is the last one written and therefore wins.
  always_comb begin
    idx   = 2'd0;
    valid = 1'b0;
    cand  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arb4.sv
// rtl/bus_arb4.sv - round-robin owner arbiter and mux sequencer for the shared result bus
//
// Purpose : grants one of four requesters the shared 4:1 word mux, drives the
//           mux selects for the owner, inserts a one-cycle turnaround between
//           owners and bounds ownership length under contention.
// Params  : MAX_HOLD  max owned cycles while another request is pending (0 = unlimited)
//           CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
// Ports   : CLK          in   clock, rising edge
//           RST_N        in   synchronous active-low reset
//           LOCK         in   owner hold request (only with BUS_ARB4_LOCK_EN)
//           REQ  [3:0]   in   level requests
//           LAST [3:0]   in   final-cycle flags, only the owner's bit is used
//           GNT  [3:0]   out  registered one-hot grant, zero when no owner
//           S1, S0       out  registered mux select = owner index
//           BUSY         out  high in OWN or TURN
// Config  : define BUS_ARB4_LOCK_EN to add the LOCK port; while LOCK=1 in OWN
//           the MAX_HOLD release is suppressed.
module bus_arb4
  import dlx_bus_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
`ifdef BUS_ARB4_LOCK_EN
  input  logic       LOCK,
`endif
  input  logic [3:0] REQ,
  input  logic [3:0] LAST,
  output logic [3:0] GNT,
  output logic       S0,
  output logic       S1,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W:0]   HOLD_LIM = (CNT_W+1)'(MAX_HOLD);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       pick_idx;
  logic             pick_valid;
  logic [1:0]       owner;
  logic [CNT_W:0]   held;
  logic             contend;
  logic             hold_hit;
  logic             lock_hold;
  logic             do_release;

  rr_pick4 u_pick (
    .req   (REQ),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef BUS_ARB4_LOCK_EN
  assign lock_hold = LOCK;
`else
  assign lock_hold = 1'b0;
`endif

  // The select registers always hold the current (or most recent) owner.
  assign owner   = {S1, S0};
  assign contend = |(REQ & ~idx_to_onehot(owner));

  // cnt counts owned edges already taken; the cycle ending now is one more.
  // Counting it here makes the grant last exactly MAX_HOLD cycles.
  assign held     = {1'b0, cnt} + 1'b1;
  assign hold_hit = (MAX_HOLD != 0) && (held >= HOLD_LIM);

  // REQ drop and LAST together still produce one release.
  assign do_release = !REQ[owner] || LAST[owner] ||
                      (hold_hit && contend && !lock_hold);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      GNT   <= '0;
      S1    <= 1'b0;
      S0    <= 1'b0;
      BUSY  <= 1'b0;
      ptr   <= 2'd0;
      cnt   <= '0;
    end else begin
      case (state)
        // TURN arbitrates exactly like IDLE, but from the pointer that the
        // release has already advanced past the previous owner.
        IDLE, TURN: begin
          if (pick_valid) begin
            state    <= OWN;
            GNT      <= idx_to_onehot(pick_idx);
            {S1, S0} <= pick_idx;
            BUSY     <= 1'b1;
            cnt      <= '0;
          end else begin
            state <= IDLE;
            GNT   <= '0;
            BUSY  <= 1'b0;
          end
        end

        OWN: begin
          if (do_release) begin
            // Selects keep the old owner so the mux output does not glitch.
            state <= TURN;
            GNT   <= '0;
            BUSY  <= 1'b1;
            ptr   <= owner + 2'd1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          GNT   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
